// File: rtl/mem_access_unit_if.sv
// Bundle of the pipeline-side and data-memory-side signals of the MEM-stage
// load/store unit. The master modport is the unit's view; the slave modport
// is the view of the surrounding pipeline and data memory.
interface mem_access_unit_if;
    // pipeline side
    logic        mem_req_i;
    logic        mem_we_i;
    logic [2:0]  func3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] load_data_o;
    logic        load_valid_o;
    logic        access_fault_o;
    logic        bus_err_o;
    // data memory side
    logic        dm_req_o;
    logic        dm_gnt_i;
    logic [31:0] dm_addr_o;
    logic        dm_we_o;
    logic [3:0]  dm_wstrb_o;
    logic [31:0] dm_wdata_o;
    logic        dm_rvalid_i;
    logic [31:0] dm_rdata_i;

    modport master (
        input  mem_req_i, mem_we_i, func3_i, addr_i, wdata_i,
        output stall_o, load_data_o, load_valid_o, access_fault_o, bus_err_o,
        output dm_req_o, dm_addr_o, dm_we_o, dm_wstrb_o, dm_wdata_o,
        input  dm_gnt_i, dm_rvalid_i, dm_rdata_i
    );

    modport slave (
        output mem_req_i, mem_we_i, func3_i, addr_i, wdata_i,
        input  stall_o, load_data_o, load_valid_o, access_fault_o, bus_err_o,
        input  dm_req_o, dm_addr_o, dm_we_o, dm_wstrb_o, dm_wdata_o,
        output dm_gnt_i, dm_rvalid_i, dm_rdata_i
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, request/grant/response
// handshake to data memory, byte strobes with lane-replicated store data,
// right-aligned load data for the WB-stage load filter.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no access outstanding; legal request accepted here
// S_REQ  | dm_req_o asserted from captured registers until granted
// S_WAIT | granted; waiting for rvalid or timeout
// S_DONE | one-cycle completion pulse, pipeline released
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYC);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_cnt;
    logic [29:0] r_addr_word;
    logic [1:0]  r_off;
    logic        r_we;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic        r_berr;

    logic        w_legal;
    logic        w_aligned;
    logic        w_ok;
    logic        w_accept;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic        w_stall;
    logic        w_dm_req;
    logic        w_fault;
    logic        w_lvalid;
    logic        w_berr;

    // Decode func3 into legality, alignment and the store lane pattern.
    always_comb begin
        w_legal   = 1'b0;
        w_aligned = 1'b0;
        w_wstrb   = 4'b0000;
        w_wdata   = 32'h0;
        case (bus.func3_i)
            3'b000: begin
                w_legal   = 1'b1;
                w_aligned = 1'b1;
                if (bus.mem_we_i) begin
                    w_wstrb = 4'b0001 << bus.addr_i[1:0];
                    w_wdata = {4{bus.wdata_i[7:0]}};
                end
            end
            3'b001: begin
                w_legal   = 1'b1;
                w_aligned = ~bus.addr_i[0];
                if (bus.mem_we_i) begin
                    w_wstrb = bus.addr_i[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{bus.wdata_i[15:0]}};
                end
            end
            3'b010: begin
                w_legal   = 1'b1;
                w_aligned = (bus.addr_i[1:0] == 2'b00);
                if (bus.mem_we_i) begin
                    w_wstrb = 4'b1111;
                    w_wdata = bus.wdata_i;
                end
            end
            3'b100: begin
                w_legal   = ~bus.mem_we_i;
                w_aligned = 1'b1;
            end
            3'b101: begin
                w_legal   = ~bus.mem_we_i;
                w_aligned = ~bus.addr_i[0];
            end
            default: begin
                w_legal   = 1'b0;
                w_aligned = 1'b0;
            end
        endcase
    end

    assign w_ok      = w_legal & w_aligned;
    assign w_accept  = rst_n & (r_state == S_IDLE) & bus.mem_req_i & w_ok;
    // WAIT may last at most TIMEOUT_CYC cycles; the last one still accepts rvalid.
    assign w_timeout = (r_cnt >= (C_TIMEOUT - 8'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state and control outputs; everything forced low while in reset.
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_dm_req    = 1'b0;
        w_fault     = 1'b0;
        w_lvalid    = 1'b0;
        w_berr      = 1'b0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    w_stall = w_accept;
                    w_fault = bus.mem_req_i & ~w_ok;
                    if (w_accept) w_state_nxt = S_REQ;
                end
                S_REQ: begin
                    w_stall  = 1'b1;
                    w_dm_req = 1'b1;
                    if (bus.dm_gnt_i) w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    w_stall = 1'b1;
                    if (bus.dm_rvalid_i || w_timeout) w_state_nxt = S_DONE;
                end
                S_DONE: begin
                    w_lvalid    = ~r_we & ~r_berr;
                    w_berr      = r_berr;
                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Timeout counter: cleared on grant, saturating count while waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= 8'h00;
        end else if (r_state == S_REQ && bus.dm_gnt_i) begin
            r_cnt <= 8'h00;
        end else if (r_state == S_WAIT && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Capture the request on accept and the response (or timeout) in WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr_word <= 30'h0;
            r_off       <= 2'b00;
            r_we        <= 1'b0;
            r_wstrb     <= 4'b0000;
            r_wdata     <= 32'h0;
            r_load_data <= 32'h0;
            r_berr      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr_word <= bus.addr_i[31:2];
                r_off       <= bus.addr_i[1:0];
                r_we        <= bus.mem_we_i;
                r_wstrb     <= w_wstrb;
                r_wdata     <= w_wdata;
                r_berr      <= 1'b0;
            end
            if (r_state == S_WAIT) begin
                if (bus.dm_rvalid_i) begin
                    r_load_data <= bus.dm_rdata_i >> {r_off, 3'b000};
                end else if (w_timeout) begin
                    r_load_data <= 32'h0;
                    r_berr      <= 1'b1;
                end
            end
        end
    end

    assign bus.stall_o        = w_stall;
    assign bus.access_fault_o = w_fault;
    assign bus.load_valid_o   = w_lvalid;
    assign bus.bus_err_o      = w_berr;
    assign bus.load_data_o    = r_load_data;
    assign bus.dm_req_o       = w_dm_req;
    assign bus.dm_addr_o      = w_dm_req ? {r_addr_word, 2'b00} : 32'h0;
    assign bus.dm_we_o        = w_dm_req & r_we;
    assign bus.dm_wstrb_o     = w_dm_req ? r_wstrb : 4'b0000;
    assign bus.dm_wdata_o     = w_dm_req ? r_wdata : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: each transaction's timeline (accept, grant
// delay, response delay or timeout) is turned into per-cycle expected
// outputs; one negedge process compares every output every checked cycle.
module tb_mem_access_unit;

    localparam int T = 4;

    logic clk;
    logic rst_n;

    mem_access_unit_if bus_if ();

    mem_access_unit #(.TIMEOUT_CYC(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          chk_en = 1'b0;
    bit          exp_stall, exp_req, exp_we, exp_lvalid, exp_berr, exp_fault;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_addr, exp_wdata, exp_ldata;
    logic [31:0] m_load_data = 32'h0;

    int          stall_seen, lv_seen, req_seen, fault_seen, berr_seen;
    logic [31:0] last_addr, last_wdata;
    logic [3:0]  last_wstrb;
    logic        last_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the expectations set by the driver.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall",     32'(bus_if.stall_o),        32'(exp_stall));
            chk("dm_req",    32'(bus_if.dm_req_o),       32'(exp_req));
            chk("dm_addr",   bus_if.dm_addr_o,           exp_addr);
            chk("dm_we",     32'(bus_if.dm_we_o),        32'(exp_we));
            chk("dm_wstrb",  32'(bus_if.dm_wstrb_o),     32'(exp_wstrb));
            chk("dm_wdata",  bus_if.dm_wdata_o,          exp_wdata);
            chk("lvalid",    32'(bus_if.load_valid_o),   32'(exp_lvalid));
            chk("bus_err",   32'(bus_if.bus_err_o),      32'(exp_berr));
            chk("fault",     32'(bus_if.access_fault_o), 32'(exp_fault));
            chk("load_data", bus_if.load_data_o,         exp_ldata);
            if (bus_if.stall_o)        stall_seen++;
            if (bus_if.load_valid_o)   lv_seen++;
            if (bus_if.access_fault_o) fault_seen++;
            if (bus_if.bus_err_o)      berr_seen++;
            if (bus_if.dm_req_o) begin
                req_seen++;
                last_addr  = bus_if.dm_addr_o;
                last_wstrb = bus_if.dm_wstrb_o;
                last_wdata = bus_if.dm_wdata_o;
                last_we    = bus_if.dm_we_o;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic bit legal_aligned(input bit we, input logic [2:0] f3, input logic [31:0] a);
        int size;
        case (f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    return 1'b0;
        endcase
        if (we && f3[2]) return 1'b0;
        return (int'(a[1:0]) % size) == 0;
    endfunction

    function automatic void store_lanes(input bit we, input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] wd, output logic [3:0] s, output logic [31:0] d);
        int off;
        off = int'(a[1:0]);
        s = 4'b0000;
        d = 32'h0;
        if (we) begin
            case (f3)
                3'd0: begin
                    s = 4'(1 << off);
                    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[7:0];
                end
                3'd1: begin
                    s = 4'(3 << off);
                    d = {wd[15:0], wd[15:0]};
                end
                default: begin
                    s = 4'hF;
                    d = wd;
                end
            endcase
        end
    endfunction

    task automatic clear_seen();
        stall_seen = 0; lv_seen = 0; req_seen = 0; fault_seen = 0; berr_seen = 0;
        last_addr = 32'h0; last_wstrb = 4'h0; last_wdata = 32'h0; last_we = 1'b0;
    endtask

    task automatic set_exp_idle();
        exp_stall = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_lvalid = 1'b0;
        exp_berr = 1'b0; exp_fault = 1'b0; exp_wstrb = 4'h0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_ldata = m_load_data;
    endtask

    task automatic idle_cycles(input int n, input bit force_rvalid);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus_if.mem_req_i   = 1'b0;
            bus_if.mem_we_i    = 1'($urandom_range(0, 1));
            bus_if.func3_i     = 3'($urandom_range(0, 7));
            bus_if.addr_i      = $urandom;
            bus_if.wdata_i     = $urandom;
            bus_if.dm_gnt_i    = 1'($urandom_range(0, 1));
            bus_if.dm_rvalid_i = force_rvalid ? 1'b1 : 1'($urandom_range(0, 1));
            bus_if.dm_rdata_i  = $urandom;
            set_exp_idle();
        end
    endtask

    // One instruction: g cycles of grant back-pressure, response after r WAIT
    // cycles (r >= T means no response, i.e. timeout).
    task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input int g, input int r);
        logic [3:0]  es;
        logic [31:0] ed;
        int G, D, off;
        bit tmo;
        clear_seen();
        store_lanes(we, f3, addr, wd, es, ed);
        off = int'(addr[1:0]);
        if (!legal_aligned(we, f3, addr)) begin
            @(posedge clk); #1;
            bus_if.mem_req_i = 1'b1; bus_if.mem_we_i = we; bus_if.func3_i = f3;
            bus_if.addr_i = addr; bus_if.wdata_i = wd;
            bus_if.dm_gnt_i    = 1'($urandom_range(0, 1));
            bus_if.dm_rvalid_i = 1'($urandom_range(0, 1));
            bus_if.dm_rdata_i  = $urandom;
            set_exp_idle();
            exp_fault = 1'b1;
            return;
        end
        G   = g + 1;
        tmo = (r >= T);
        D   = tmo ? G + 1 + T : G + 2 + r;
        for (int k = 0; k <= D; k++) begin
            @(posedge clk); #1;
            bus_if.mem_req_i = 1'b1; bus_if.mem_we_i = we; bus_if.func3_i = f3;
            bus_if.addr_i = addr; bus_if.wdata_i = wd;
            bus_if.dm_rdata_i = $urandom;
            if (k >= 1 && k <= G) begin
                bus_if.dm_gnt_i    = (k == G);
                bus_if.dm_rvalid_i = 1'($urandom_range(0, 1));
            end else if (k > G && k < D) begin
                bus_if.dm_gnt_i    = 1'($urandom_range(0, 1));
                bus_if.dm_rvalid_i = 1'b0;
                if (!tmo && k == G + 1 + r) begin
                    bus_if.dm_rvalid_i = 1'b1;
                    bus_if.dm_rdata_i  = rd;
                end
            end else begin
                bus_if.dm_gnt_i    = 1'($urandom_range(0, 1));
                bus_if.dm_rvalid_i = 1'($urandom_range(0, 1));
            end
            if (k == D) m_load_data = tmo ? 32'h0 : (rd >> (8 * off));
            exp_stall  = (k < D);
            exp_req    = (k >= 1 && k <= G);
            exp_addr   = exp_req ? {addr[31:2], 2'b00} : 32'h0;
            exp_we     = exp_req && we;
            exp_wstrb  = exp_req ? es : 4'h0;
            exp_wdata  = exp_req ? ed : 32'h0;
            exp_lvalid = (k == D) && !we && !tmo;
            exp_berr   = (k == D) && tmo;
            exp_fault  = 1'b0;
            exp_ldata  = m_load_data;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_if.mem_req_i = 1'b0; bus_if.mem_we_i = 1'b0; bus_if.func3_i = 3'd0;
        bus_if.addr_i = 32'h0; bus_if.wdata_i = 32'h0; bus_if.dm_gnt_i = 1'b0;
        bus_if.dm_rvalid_i = 1'b0; bus_if.dm_rdata_i = 32'h0;
        set_exp_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2, 1'b0);

        // lb from byte 3
        run_txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 0);
        idle_cycles(1, 1'b0);
        chk("lb_addr",  last_addr, 32'h0000_1000);
        chk("lb_wstrb", 32'(last_wstrb), 32'h0);
        chk("lb_stall_cycles", 32'(stall_seen), 32'd3);
        chk("lb_lvalid_pulses", 32'(lv_seen), 32'd1);
        chk("lb_data",  bus_if.load_data_o, 32'h0000_0080);

        // sh to upper half
        run_txn(1'b1, 3'b001, 32'h0000_2002, 32'h1234_BEEF, 32'h5555_AAAA, 0, 1);
        idle_cycles(1, 1'b0);
        chk("sh_we",    32'(last_we), 32'd1);
        chk("sh_wstrb", 32'(last_wstrb), 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        chk("sh_lvalid_pulses", 32'(lv_seen), 32'd0);

        // misaligned lw and illegal func3
        run_txn(1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 0, 0);
        idle_cycles(1, 1'b0);
        chk("lw_mis_fault", 32'(fault_seen), 32'd1);
        chk("lw_mis_req",   32'(req_seen), 32'd0);
        run_txn(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 0, 0);
        idle_cycles(1, 1'b0);
        chk("f3_011_fault", 32'(fault_seen), 32'd1);
        chk("f3_011_stall", 32'(stall_seen), 32'd0);

        // sw with 3 cycles of grant back-pressure
        run_txn(1'b1, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'h0, 3, 0);
        idle_cycles(1, 1'b0);
        chk("sw_req_cycles",   32'(req_seen), 32'd4);
        chk("sw_stall_cycles", 32'(stall_seen), 32'd6);
        chk("sw_wdata",        last_wdata, 32'hCAFE_F00D);

        // timeout, then a late response in IDLE
        run_txn(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 9);
        idle_cycles(1, 1'b1);
        chk("tmo_berr_pulses",  32'(berr_seen), 32'd1);
        chk("tmo_lvalid",       32'(lv_seen), 32'd0);
        chk("tmo_stall_cycles", 32'(stall_seen), 32'd6);
        chk("tmo_late_data",    bus_if.load_data_o, 32'h0);

        // give load_data a non-zero value, then reset in the middle of an access
        run_txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h1122_3344, 0, 0);
        idle_cycles(1, 1'b0);
        chk_en = 1'b0;
        @(posedge clk); #1;
        bus_if.mem_req_i = 1'b1; bus_if.mem_we_i = 1'b0; bus_if.func3_i = 3'b010;
        bus_if.addr_i = 32'h0000_5000; bus_if.dm_gnt_i = 1'b0; bus_if.dm_rvalid_i = 1'b0;
        @(posedge clk); #1;
        bus_if.dm_gnt_i = 1'b1;
        @(posedge clk); #1;
        bus_if.dm_gnt_i = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_if.mem_req_i = 1'b0;
        bus_if.dm_rvalid_i = 1'b1;
        bus_if.dm_rdata_i = 32'hFFFF_FFFF;
        m_load_data = 32'h0;
        set_exp_idle();
        chk_en = 1'b1;
        idle_cycles(1, 1'b0);
        run_txn(1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_AB00, 0, 0);
        idle_cycles(1, 1'b0);
        chk("lbu_after_rst", bus_if.load_data_o, 32'h0000_00AB);

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 5));
            idle_cycles($urandom_range(0, 2), 1'b0);
        end
        idle_cycles(1, 1'b0);
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store unit of the RV32I core. It accepts one memory instruction at a time from the EX/MEM pipeline register and checks alignment. It drives a request/grant/response handshake to data memory, generates byte strobes and lane-replicated store data, and returns load data right-aligned (shifted by addr[1:0]) to the WB-stage load filter. That filter then applies sign or zero extension according to func3. The unit stalls the pipeline while an access is outstanding.

Parameters:
TIMEOUT_CYC, 255, max cycles spent in WAIT before bus error (1..255; counter is 8 bits)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
mem_req_i  in  1  EX/MEM holds a load/store; held stable while stall_o=1
mem_we_i  in  1  1=store, 0=load
func3_i  in  3  RV32I func3 (lb/lh/lw/lbu/lhu, sb/sh/sw)
addr_i  in  32  byte address
wdata_i  in  32  store data (rs2), low bits significant
stall_o  out  1  freeze IF..MEM
load_data_o  out  32  rdata >> 8*addr[1:0], zero-filled; raw input to load filter
load_valid_o  out  1  1-cycle pulse, load_data_o valid
access_fault_o  out  1  1-cycle pulse: misaligned or illegal func3
bus_err_o  out  1  1-cycle pulse: response timeout
dm_req_o  out  1  memory request
dm_gnt_i  in  1  memory accepts request this cycle
dm_addr_o  out  32  {addr[31:2],2'b00}
dm_we_o  out  1  write enable
dm_wstrb_o  out  4  active-high byte strobes, 0 for loads
dm_wdata_o  out  32  lane-replicated store data
dm_rvalid_i  in  1  read data / write ack valid
dm_rdata_i  in  32  read data word

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, timeout counter=0. All outputs 0. A pending access is abandoned. Any dm_rvalid_i arriving later while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- Legal func3: loads 000,001,010,100,101; stores 000,001,010. Alignment rules: half-word needs addr[0]=0; word needs addr[1:0]=00.
- IDLE, mem_req_i=1, illegal func3 or misaligned:
  - access_fault_o=1 for one cycle; stall_o=0; no dm_req_o; stay in IDLE.
- IDLE, mem_req_i=1, legal and aligned:
  - stall_o=1 combinationally.
  - Capture addr, we, func3, strobes and wdata into registers.
  - Next state REQ.
- REQ: dm_req_o=1; dm_addr_o, dm_we_o, dm_wstrb_o and dm_wdata_o come from registers and stay stable until dm_gnt_i=1. On grant go to WAIT and clear the counter. stall_o=1.
- WAIT: stall_o=1; counter increments each cycle.
  - dm_rvalid_i=1: capture (dm_rdata_i >> 8*addr_q[1:0]) into load_data_o register; go to DONE. The capture also happens for stores; the value is unused.
  - Counter reaches TIMEOUT_CYC with no rvalid: load_data_o=0, set bus_err flag, go to DONE.
  - dm_rvalid_i is sampled only in WAIT, never in the grant cycle.
- DONE:
  - stall_o=0.
  - load_valid_o=1 if the access was a load with no timeout.
  - bus_err_o=1 if it timed out.
  - Go to IDLE unconditionally. The pipeline advances at this edge, and mem_req_i still high in DONE is not re-accepted.
- Store strobes / data:
  - sb: strobe 0001<<addr[1:0]; wdata {4{wdata_i[7:0]}}.
  - sh: strobe 0011 or 1100 by addr[1]; wdata {2{wdata_i[15:0]}}.
  - sw: strobe 1111; wdata as-is.
- Loads: dm_wstrb_o=0, dm_we_o=0; dm_wdata_o is don't-care and driven 0.
- Outside REQ: dm_req_o=0.
- load_data_o holds its last value outside DONE.
- Minimum latency (grant in REQ, rvalid on first WAIT cycle): accept→DONE takes 3 cycles, i.e. 3 stall cycles.
- Counter saturates; no wrap-around.

Test Plan:
- Load byte: lb addr 0x0000_1003, dm_rdata_i=0x80FF_1234, gnt immediate, rvalid next cycle → dm_addr_o 0x0000_1000, wstrb 0000, stall_o high exactly 3 cycles, DONE load_data_o=0x0000_0080, load_valid_o 1 cycle.
- Store half-word: sh addr 0x0000_2002, wdata_i=0x1234_BEEF → dm_we_o=1, wstrb 1100, dm_wdata_o=0xBEEF_BEEF; on rvalid → DONE with load_valid_o=0.
- Misaligned word: lw addr 0x0000_1002 → access_fault_o 1 cycle, stall_o=0, dm_req_o never asserted; same for func3=011.
- Grant back-pressure: sw with dm_gnt_i low 3 cycles → dm_req_o/addr/strobes/wdata stable all 4 REQ cycles, stall_o held, single grant accepted.
- Timeout: TIMEOUT_CYC=4, lw, grant then no rvalid → bus_err_o pulse 4 cycles after entering WAIT, load_valid_o=0, back to IDLE; a late rvalid is ignored.
- Reset mid-access: rst_n low during WAIT → next cycle all outputs 0, state IDLE; new lbu addr 0x1 with rdata 0x0000_AB00 → load_data_o=0x0000_00AB.
